// File: rtl/si4463_pkg.sv
// Shared constants for the Si4463 command sequencer: FSM state codes, radio
// opcodes/flags and the response-length clamp helper.
package si4463_pkg;

  // Controller state encoding.
  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StCmd     = 3'd1;
  localparam logic [2:0] StGap1    = 3'd2;
  localparam logic [2:0] StPoll    = 3'd3;
  localparam logic [2:0] StPollGap = 3'd4;
  localparam logic [2:0] StRsp     = 3'd5;
  localparam logic [2:0] StFinish  = 3'd6;

  localparam logic [7:0] READ_CMD_BUFF = 8'h44;
  localparam logic [7:0] CTS_READY     = 8'hFF;
  localparam logic [7:0] DUMMY_BYTE    = 8'h00;

  function automatic logic [4:0] clamp_len(input logic [4:0] len, input logic [4:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/si4463_spi_byte.sv
// Mode-0 SPI byte shifter: MSB first, MOSI updated while SCLK is low, MISO
// sampled on SCLK rising edges. Each SCLK half-period lasts CLK_DIV clocks.
// done pulses one clock after the 8th rising edge (rx_byte valid from then on);
// busy stays high until the final falling edge has completed.
module si4463_spi_byte #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic [7:0] rx_byte,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       mosi
);

  logic [15:0] div_q;
  logic [2:0]  bit_q;
  logic [6:0]  tx_sr_q;
  logic [6:0]  rx_sr_q;
  logic        half_end;

  assign half_end = (div_q == 16'(CLK_DIV - 1));

  // Half-period divider, bit counter and shift registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      div_q   <= '0;
      bit_q   <= '0;
      tx_sr_q <= '0;
      rx_sr_q <= '0;
      rx_byte <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy    <= 1'b1;
          div_q   <= '0;
          bit_q   <= '0;
          sclk    <= 1'b0;
          tx_sr_q <= tx_byte[6:0];
          mosi    <= tx_byte[7];
        end
      end else if (half_end) begin
        div_q <= '0;
        sclk  <= ~sclk;
        if (!sclk) begin
          // Rising edge: capture MISO.
          rx_sr_q <= {rx_sr_q[5:0], miso};
          if (bit_q == 3'd7) begin
            rx_byte <= {rx_sr_q, miso};
            done    <= 1'b1;
          end
        end else if (bit_q == 3'd7) begin
          busy <= 1'b0;
        end else begin
          // Falling edge: present the next bit.
          bit_q   <= bit_q + 3'd1;
          mosi    <= tx_sr_q[6];
          tx_sr_q <= {tx_sr_q[5:0], 1'b0};
        end
      end else begin
        div_q <= div_q + 16'd1;
      end
    end
  end

endmodule

// File: rtl/si4463_cmd_ctrl.sv
// Si4463 command sequencer: shifts a host command out over SPI, polls CTS with
// READ_CMD_BUFF, then reads back the requested number of response bytes.
// Optional CTS poll timeout is enabled by defining SI4463_CTS_TIMEOUT_EN.
module si4463_cmd_ctrl
  import si4463_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned NSEL_GAP     = 4,
  parameter int unsigned MAX_RSP_LEN  = 16,
  parameter int unsigned CTS_POLL_MAX = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  input  logic       cmd_last,
  input  logic [4:0] rsp_len,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_last,
  output logic       busy,
  output logic       done,
  output logic       timeout_err,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_nsel
);

  logic [2:0]  state_q, state_d;
  logic [15:0] gap_q, gap_d;
  logic        last_q, last_d;
  logic [4:0]  len_q, len_d;
  logic [4:0]  rsp_cnt_q, rsp_cnt_d;
  logic [9:0]  poll_cnt_q, poll_cnt_d;
  logic        poll_ph_q, poll_ph_d;
  logic        nsel_q, nsel_d;
  logic        timeout_q, timeout_d;
  logic        done_d, rsp_valid_d, rsp_last_d;
  logic [7:0]  rsp_data_d;

  logic        spi_start, spi_busy, spi_done, spi_busy_prev_q;
  logic [7:0]  spi_tx, spi_rx;
  logic        byte_end, gap_end, accept;

  si4463_spi_byte #(
    .CLK_DIV(CLK_DIV)
  ) u_spi (
    .clk    (clk),
    .rst    (rst),
    .start  (spi_start),
    .tx_byte(spi_tx),
    .miso   (spi_miso),
    .rx_byte(spi_rx),
    .busy   (spi_busy),
    .done   (spi_done),
    .sclk   (spi_sclk),
    .mosi   (spi_mosi)
  );

  // Ready in IDLE, or between command bytes once the shifter is free.
  assign cmd_ready   = !rst && ((state_q == StIdle) ||
                                ((state_q == StCmd) && !spi_busy && !last_q));
  assign accept      = cmd_valid && cmd_ready;
  assign byte_end    = spi_busy_prev_q && !spi_busy;
  assign gap_end     = (gap_q == 16'(NSEL_GAP - 1));
  assign busy        = (state_q != StIdle);
  assign spi_nsel    = nsel_q;
  assign timeout_err = timeout_q;

  // Next-state, shifter start and response strobe generation.
  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    last_d      = last_q;
    len_d       = len_q;
    rsp_cnt_d   = rsp_cnt_q;
    poll_cnt_d  = poll_cnt_q;
    poll_ph_d   = poll_ph_q;
    nsel_d      = nsel_q;
    timeout_d   = timeout_q;
    done_d      = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_last_d  = 1'b0;
    rsp_data_d  = rsp_data;
    spi_start   = 1'b0;
    spi_tx      = DUMMY_BYTE;
    case (state_q)
      StIdle: begin
        if (accept) begin
          spi_start  = 1'b1;
          spi_tx     = cmd_data;
          state_d    = StCmd;
          len_d      = clamp_len(rsp_len, 5'(MAX_RSP_LEN));
          last_d     = cmd_last;
          timeout_d  = 1'b0;
          nsel_d     = 1'b0;
          poll_cnt_d = '0;
        end
      end
      StCmd: begin
        if (accept) begin
          spi_start = 1'b1;
          spi_tx    = cmd_data;
          last_d    = cmd_last;
        end else if (byte_end && last_q) begin
          state_d = StGap1;
          nsel_d  = 1'b1;
          gap_d   = '0;
        end
      end
      StGap1, StPollGap: begin
        if (gap_end) begin
          state_d   = StPoll;
          nsel_d    = 1'b0;
          poll_ph_d = 1'b0;
          spi_start = 1'b1;
          spi_tx    = READ_CMD_BUFF;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      StPoll: begin
        if (byte_end) begin
          if (!poll_ph_q) begin
            // Opcode sent; clock out the dummy byte that returns CTS.
            poll_ph_d = 1'b1;
            spi_start = 1'b1;
          end else if (spi_rx == CTS_READY) begin
            if (len_q != 5'd0) begin
              state_d   = StRsp;
              rsp_cnt_d = '0;
              spi_start = 1'b1;
            end else begin
              state_d = StFinish;
              nsel_d  = 1'b1;
              gap_d   = '0;
            end
          end else begin
            state_d    = StPollGap;
            nsel_d     = 1'b1;
            gap_d      = '0;
            poll_cnt_d = poll_cnt_q + 10'd1;
`ifdef SI4463_CTS_TIMEOUT_EN
            if (poll_cnt_d == 10'(CTS_POLL_MAX)) begin
              state_d   = StFinish;
              timeout_d = 1'b1;
            end
`endif
          end
        end
      end
      StRsp: begin
        if (spi_done) begin
          rsp_cnt_d   = rsp_cnt_q + 5'd1;
          rsp_valid_d = 1'b1;
          rsp_last_d  = (rsp_cnt_d == len_q);
          rsp_data_d  = spi_rx;
        end
        if (byte_end) begin
          if (rsp_cnt_q == len_q) begin
            state_d = StFinish;
            nsel_d  = 1'b1;
            gap_d   = '0;
          end else begin
            spi_start = 1'b1;
          end
        end
      end
      StFinish: begin
        if (gap_end) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset forces NSEL high immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      gap_q           <= '0;
      last_q          <= 1'b0;
      len_q           <= '0;
      rsp_cnt_q       <= '0;
      poll_cnt_q      <= '0;
      poll_ph_q       <= 1'b0;
      nsel_q          <= 1'b1;
      timeout_q       <= 1'b0;
      done            <= 1'b0;
      rsp_valid       <= 1'b0;
      rsp_last        <= 1'b0;
      rsp_data        <= '0;
      spi_busy_prev_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      gap_q           <= gap_d;
      last_q          <= last_d;
      len_q           <= len_d;
      rsp_cnt_q       <= rsp_cnt_d;
      poll_cnt_q      <= poll_cnt_d;
      poll_ph_q       <= poll_ph_d;
      nsel_q          <= nsel_d;
      timeout_q       <= timeout_d;
      done            <= done_d;
      rsp_valid       <= rsp_valid_d;
      rsp_last        <= rsp_last_d;
      rsp_data        <= rsp_data_d;
      spi_busy_prev_q <= spi_busy;
    end
  end

endmodule

// File: tb/tb_si4463_cmd_ctrl.sv
// Directed bench for si4463_cmd_ctrl with a mode-0 SPI radio model.
// The timeout scenario runs only when SI4463_CTS_TIMEOUT_EN is defined.
module tb_si4463_cmd_ctrl;

  localparam int unsigned CLK_DIV      = 2;
  localparam int unsigned NSEL_GAP     = 3;
  localparam int unsigned MAX_RSP_LEN  = 16;
  localparam int unsigned CTS_POLL_MAX = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_last = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic [4:0] rsp_len = 5'd0;
  logic       spi_miso = 1'b0;
  logic       cmd_ready, rsp_valid, rsp_last, busy, done, timeout_err;
  logic       spi_sclk, spi_mosi, spi_nsel;
  logic [7:0] rsp_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  si4463_cmd_ctrl #(
    .CLK_DIV     (CLK_DIV),
    .NSEL_GAP    (NSEL_GAP),
    .MAX_RSP_LEN (MAX_RSP_LEN),
    .CTS_POLL_MAX(CTS_POLL_MAX)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_data   (cmd_data),
    .cmd_last   (cmd_last),
    .rsp_len    (rsp_len),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_last   (rsp_last),
    .busy       (busy),
    .done       (done),
    .timeout_err(timeout_err),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_nsel   (spi_nsel)
  );

  // Radio model: logs every MOSI byte, answers CTS after not_ready polls.
  logic [7:0] resp_mem [0:31];
  logic [7:0] mosi_log [$];
  logic [7:0] m_rx = 8'h00, m_tx = 8'h00, m_first = 8'h00;
  int         m_bit = 0, m_idx = 0, poll_num = 0, not_ready = 0, nsel_rises = 0;

  always @(negedge spi_nsel) begin
    m_bit = 0; m_idx = 0; m_first = 8'h00; m_tx = 8'h00; spi_miso = 1'b0;
  end

  always @(posedge spi_nsel) nsel_rises++;

  always @(posedge spi_sclk) if (spi_nsel === 1'b0) begin
    m_rx = {m_rx[6:0], spi_mosi};
    m_bit++;
    if (m_bit == 8) begin
      mosi_log.push_back(m_rx);
      if (m_idx == 0) m_first = m_rx;
    end
  end

  always @(negedge spi_sclk) if (spi_nsel === 1'b0) begin
    if (m_bit == 8) begin
      m_bit = 0;
      m_idx++;
      if (m_first == 8'h44 && m_idx == 1) begin
        poll_num++;
        m_tx = (poll_num > not_ready) ? 8'hFF : 8'h00;
      end else if (m_first == 8'h44 && m_idx >= 2 && m_idx < 34) begin
        m_tx = resp_mem[m_idx-2];
      end else begin
        m_tx = 8'h00;
      end
    end else begin
      m_tx = {m_tx[6:0], 1'b0};
    end
    spi_miso = m_tx[7];
  end

  // Output monitor, sampled on the falling system clock edge.
  logic [7:0] rsp_got [$];
  logic       last_got [$];
  int         done_cnt = 0;

  always @(negedge clk) if (!rst) begin
    if (done === 1'b1) done_cnt++;
    if (rsp_valid === 1'b1) begin
      rsp_got.push_back(rsp_data);
      last_got.push_back(rsp_last);
    end
  end

  logic [7:0] cmd_bytes [$];
  logic [7:0] exp_log [$];

  task automatic clear_logs();
    mosi_log.delete(); rsp_got.delete(); last_got.delete(); exp_log.delete();
    done_cnt = 0; poll_num = 0; nsel_rises = 0;
  endtask

  // Offers cmd_bytes with valid/ready; optional stall after byte stall_after.
  task automatic send_cmd(input int stall_after, input int stall_len, output bit ok);
    ok = 1'b1;
    for (int i = 0; i < cmd_bytes.size(); i++) begin
      int budget;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_data = cmd_bytes[i]; cmd_last = (i == cmd_bytes.size() - 1);
      #1;
      budget = 0;
      while (cmd_ready !== 1'b1 && budget < 2000) begin
        @(negedge clk); #1; budget++;
      end
      if (cmd_ready !== 1'b1) begin ok = 1'b0; break; end
      @(negedge clk);
      cmd_valid = 1'b0; cmd_last = 1'b0;
      if (i == stall_after - 1) repeat (stall_len) @(negedge clk);
    end
    cmd_valid = 1'b0; cmd_last = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({cmd_ready, rsp_valid, rsp_last, busy, done, timeout_err, spi_sclk, spi_mosi, spi_nsel}
        !== 9'b000000001) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 000000001",
               {cmd_ready, rsp_valid, rsp_last, busy, done, timeout_err, spi_sclk, spi_mosi,
                spi_nsel});
    end
    n_checks++;
    if (rsp_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_rsp_data: got %h want 00", rsp_data);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: ready=%b busy=%b want 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_nop();
    bit ok;
    clear_logs();
    not_ready = 0; rsp_len = 5'd0;
    cmd_bytes = '{8'h00};
    send_cmd(0, 0, ok);
    n_checks++;
    if (!ok || busy !== 1'b1) begin
      n_fail++; $display("FAIL nop_accept: ok=%b busy=%b want 1 1", ok, busy);
    end
    wait_done(ok);
    exp_log = '{8'h00, 8'h44, 8'h00};
    n_checks++;
    if (!ok || mosi_log != exp_log) begin
      n_fail++; $display("FAIL nop_mosi: done_seen=%b bytes=%p want %p", ok, mosi_log, exp_log);
    end
    n_checks++;
    if (done_cnt != 1 || rsp_got.size() != 0 || poll_num != 1) begin
      n_fail++;
      $display("FAIL nop_counts: done=%0d rsp=%0d polls=%0d want 1 0 1",
               done_cnt, rsp_got.size(), poll_num);
    end
  endtask

  task automatic test_part_info();
    bit ok;
    logic [63:0] pi;
    pi = 64'h4463_1186_2233_0F12;
    clear_logs();
    for (int i = 0; i < 8; i++) resp_mem[i] = pi[63-8*i -: 8];
    not_ready = 2; rsp_len = 5'd8;
    cmd_bytes = '{8'h01};
    send_cmd(0, 0, ok);
    wait_done(ok);
    n_checks++;
    if (!ok || poll_num != 3) begin
      n_fail++; $display("FAIL part_info_polls: done_seen=%b polls=%0d want 1 3", ok, poll_num);
    end
    exp_log = '{8'h01, 8'h44, 8'h00, 8'h44, 8'h00, 8'h44, 8'h00};
    for (int i = 0; i < 8; i++) exp_log.push_back(8'h00);
    n_checks++;
    if (mosi_log != exp_log) begin
      n_fail++; $display("FAIL part_info_mosi: got %p want %p", mosi_log, exp_log);
    end
    n_checks++;
    if (rsp_got.size() != 8) begin
      n_fail++; $display("FAIL part_info_rsp_count: got %0d want 8", rsp_got.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (rsp_got[i] !== pi[63-8*i -: 8] || last_got[i] !== (i == 7)) begin
          n_fail++;
          $display("FAIL part_info_rsp%0d: data=%h last=%b want %h %b",
                   i, rsp_got[i], last_got[i], pi[63-8*i -: 8], (i == 7));
        end
      end
    end
    n_checks++;
    if (done_cnt != 1 || timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL part_info_done: done=%0d terr=%b want 1 0", done_cnt, timeout_err);
    end
  endtask

  task automatic test_stall();
    bit ok;
    clear_logs();
    not_ready = 0; rsp_len = 5'd0;
    cmd_bytes = '{8'h11, 8'h00, 8'h02, 8'h20, 8'hAB, 8'hCD};
    send_cmd(3, 50, ok);
    wait_done(ok);
    exp_log = '{8'h11, 8'h00, 8'h02, 8'h20, 8'hAB, 8'hCD, 8'h44, 8'h00};
    n_checks++;
    if (!ok || mosi_log != exp_log) begin
      n_fail++; $display("FAIL stall_mosi: done_seen=%b got %p want %p", ok, mosi_log, exp_log);
    end
    n_checks++;
    if (nsel_rises != 2) begin
      n_fail++; $display("FAIL stall_nsel_rises: got %0d want 2", nsel_rises);
    end
  endtask

`ifdef SI4463_CTS_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    clear_logs();
    not_ready = 1000; rsp_len = 5'd4;
    cmd_bytes = '{8'h01};
    send_cmd(0, 0, ok);
    wait_done(ok);
    n_checks++;
    if (!ok || poll_num != 5 || timeout_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout: done_seen=%b polls=%0d terr=%b want 1 5 1", ok, poll_num,
               timeout_err);
    end
    n_checks++;
    if (done_cnt != 1 || rsp_got.size() != 0) begin
      n_fail++; $display("FAIL timeout_counts: done=%0d rsp=%0d want 1 0", done_cnt, rsp_got.size());
    end
    clear_logs();
    not_ready = 0; rsp_len = 5'd0;
    cmd_bytes = '{8'h00};
    send_cmd(0, 0, ok);
    n_checks++;
    if (timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL timeout_clear: terr=%b want 0", timeout_err);
    end
    wait_done(ok);
    n_checks++;
    if (!ok || done_cnt != 1) begin
      n_fail++; $display("FAIL timeout_next_cmd: done=%0d want 1", done_cnt);
    end
  endtask
`endif

  task automatic test_reset_mid();
    bit ok;
    bit hit;
    clear_logs();
    for (int i = 0; i < 4; i++) resp_mem[i] = 8'h5A;
    not_ready = 0; rsp_len = 5'd4;
    cmd_bytes = '{8'h01};
    send_cmd(0, 0, ok);
    hit = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (m_idx == 2 && m_bit == 4 && spi_nsel === 1'b0) begin hit = 1'b1; break; end
    end
    n_checks++;
    if (!hit) begin
      n_fail++; $display("FAIL reset_mid_reach: hit=%b want 1", hit);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (spi_nsel !== 1'b1 || spi_sclk !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_pins: nsel=%b sclk=%b want 1 0", spi_nsel, spi_sclk);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    n_checks++;
    if (done_cnt != 0 || busy !== 1'b0 || rsp_got.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: done=%0d busy=%b rsp=%0d want 0 0 0", done_cnt, busy,
               rsp_got.size());
    end
    clear_logs();
    rsp_len = 5'd0;
    cmd_bytes = '{8'h00};
    send_cmd(0, 0, ok);
    wait_done(ok);
    exp_log = '{8'h00, 8'h44, 8'h00};
    n_checks++;
    if (!ok || done_cnt != 1 || mosi_log != exp_log) begin
      n_fail++;
      $display("FAIL reset_mid_recover: done=%0d bytes=%p want 1 %p", done_cnt, mosi_log, exp_log);
    end
  endtask

  task automatic test_clamp();
    bit ok;
    int lasts;
    clear_logs();
    for (int i = 0; i < 32; i++) resp_mem[i] = 8'hA0 + 8'(i);
    not_ready = 0; rsp_len = 5'd31;
    cmd_bytes = '{8'h01};
    send_cmd(0, 0, ok);
    wait_done(ok);
    n_checks++;
    if (!ok || rsp_got.size() != 16) begin
      n_fail++; $display("FAIL clamp_count: got %0d want 16", rsp_got.size());
    end else begin
      lasts = 0;
      for (int i = 0; i < 16; i++) begin
        if (last_got[i]) lasts++;
        n_checks++;
        if (rsp_got[i] !== 8'hA0 + 8'(i)) begin
          n_fail++; $display("FAIL clamp_data%0d: got %h want %h", i, rsp_got[i], 8'hA0 + 8'(i));
        end
      end
      n_checks++;
      if (lasts != 1 || last_got[15] !== 1'b1) begin
        n_fail++; $display("FAIL clamp_last: lasts=%0d last15=%b want 1 1", lasts, last_got[15]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nop();
    test_part_info();
    test_stall();
`ifdef SI4463_CTS_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    test_clamp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
